uart_evt2_framer: RTL and testbench

Converts the raw UART byte stream from `uart_rx` into 32-bit EVT2.0 words (MSB first) and separates out idle-gap-qualified control commands. Words are presented to `voxel_bin_core` through a valid/ready interface backed by a small word FIFO. Partial words are resynchronised after an inter-byte timeout. The block sits between `uart_rx` and `voxel_bin_core`, replacing ad-hoc framing in the top level.

---
 rtl/voxel_bin_pkg.sv | 40 ++++
 rtl/uart_evt2_framer_if.sv | 29 ++
 rtl/evt2_word_fifo.sv | 73 +++++++
 rtl/uart_evt2_framer.sv | 150 +++++++++++++++
 tb/tb_uart_evt2_framer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/voxel_bin_pkg.sv
// Shared types and constants for the UART/EVT2 framing path and the voxel binning core.
package voxel_bin_pkg;

    typedef enum logic [1:0] {
        B0,
        B1,
        B2,
        B3
    } frame_state_t;

    typedef enum logic [1:0] {
        CMD_ECHO     = 2'd0,
        CMD_STATUS   = 2'd1,
        CMD_CONFIG   = 2'd2,
        CMD_SOFT_RST = 2'd3
    } cmd_code_t;

    localparam logic [7:0] CMD_BYTE_ECHO   = 8'hFF;
    localparam logic [7:0] CMD_BYTE_STATUS = 8'hFE;
    localparam logic [7:0] CMD_BYTE_CONFIG = 8'hFD;
    localparam logic [7:0] CMD_BYTE_RST    = 8'hFC;

    // Control bytes occupy 0xFC..0xFF.
    function automatic logic is_cmd_byte(logic [7:0] b);
        return b[7:2] == 6'b111111;
    endfunction

    function automatic cmd_code_t cmd_from_byte(logic [7:0] b);
        cmd_code_t code;
        case (b)
            CMD_BYTE_ECHO:   code = CMD_ECHO;
            CMD_BYTE_STATUS: code = CMD_STATUS;
            CMD_BYTE_CONFIG: code = CMD_CONFIG;
            CMD_BYTE_RST:    code = CMD_SOFT_RST;
            default:         code = CMD_ECHO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uart_evt2_framer_if.sv
// Byte input, word stream output, command and status signals of the framer.
// master: the framer itself; slave: the surrounding top level / consumer.
interface uart_evt2_framer_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [31:0]       word_out;
    logic              word_valid;
    logic              word_ready;
    logic [1:0]        cmd_code;
    logic              cmd_valid;
    logic [LevelW-1:0] fifo_level;
    logic [7:0]        drop_count;
    logic [7:0]        resync_count;

    modport master (
        input  rx_data, rx_valid, word_ready,
        output word_out, word_valid, cmd_code, cmd_valid, fifo_level, drop_count, resync_count
    );

    modport slave (
        output rx_data, rx_valid, word_ready,
        input  word_out, word_valid, cmd_code, cmd_valid, fifo_level, drop_count, resync_count
    );

endinterface

// File: rtl/evt2_word_fifo.sv
// Small synchronous word FIFO; head word is read combinationally from storage.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module evt2_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LevelW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    assign full_o  = (count_q == LevelW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + LevelW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - LevelW'(1);
        end
    end

    // State registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_evt2_framer.sv
// Frames the UART byte stream into 32-bit EVT2.0 words (MSB first), splits off
// gap-qualified control commands and resynchronises partial words on timeout.
module uart_evt2_framer
    import voxel_bin_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 104,
    parameter int unsigned CMD_GAP_BYTES = 2,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_evt2_framer_if.master         bus
);
    localparam int unsigned BYTE_CYCLES    = CLKS_PER_BIT * 10;
    localparam int unsigned CMD_GAP_CYCLES = BYTE_CYCLES * CMD_GAP_BYTES;
    localparam int unsigned TIMEOUT_CYCLES = BYTE_CYCLES * TIMEOUT_BYTES;
    localparam int unsigned IdleW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LevelW         = $clog2(FIFO_DEPTH) + 1;

    logic [IdleW-1:0]  idle_q, idle_d;
    frame_state_t      state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic              cmd_valid_q, cmd_valid_d;
    cmd_code_t         cmd_code_q, cmd_code_d;
    logic [7:0]        drop_q, drop_d;
    logic [7:0]        resync_q, resync_d;

    logic              cmd_allowed;
    logic              timed_out;
    logic              push;
    logic              pop;
    logic              resync_inc;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_head;
    logic [LevelW-1:0] fifo_level;

    // Both flags use the pre-clear idle count of the cycle the byte arrives in.
    assign cmd_allowed = (idle_q >= IdleW'(CMD_GAP_CYCLES));
    assign timed_out   = (idle_q >= IdleW'(TIMEOUT_CYCLES));
    assign pop         = !fifo_empty && bus.word_ready;

    // Idle counter: cleared by each byte, saturates at the timeout.
    always_comb begin
        idle_d = idle_q;
        if (bus.rx_valid) begin
            idle_d = '0;
        end else if (idle_q < IdleW'(TIMEOUT_CYCLES)) begin
            idle_d = idle_q + IdleW'(1);
        end
    end

    // Frame FSM: byte-indexed word assembly with command detection at word start.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        push        = 1'b0;
        resync_inc  = 1'b0;
        if (bus.rx_valid) begin
            if (state_q == B0 || timed_out) begin
                // A stale partial word is dropped and the byte starts afresh.
                resync_inc = (state_q != B0);
                if (is_cmd_byte(bus.rx_data) && cmd_allowed) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = cmd_from_byte(bus.rx_data);
                    state_d     = B0;
                end else begin
                    shift_d = {bus.rx_data, 16'h0000};
                    state_d = B1;
                end
            end else begin
                unique case (state_q)
                    B1: begin
                        shift_d[15:8] = bus.rx_data;
                        state_d       = B2;
                    end
                    B2: begin
                        shift_d[7:0] = bus.rx_data;
                        state_d      = B3;
                    end
                    B3: begin
                        push    = 1'b1;
                        state_d = B0;
                    end
                    B0: state_d = B0;
                endcase
            end
        end
    end

    // Saturating drop and resync counters.
    always_comb begin
        drop_d   = drop_q;
        resync_d = resync_q;
        if (push && fifo_full && !pop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        if (resync_inc && resync_q != 8'hFF) begin
            resync_d = resync_q + 8'd1;
        end
    end

    // State registers; idle starts saturated so a command is accepted right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q      <= IdleW'(TIMEOUT_CYCLES);
            state_q     <= B0;
            shift_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_ECHO;
            drop_q      <= '0;
            resync_q    <= '0;
        end else begin
            idle_q      <= idle_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            drop_q      <= drop_d;
            resync_q    <= resync_d;
        end
    end

    evt2_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({shift_q, bus.rx_data}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus.word_out     = fifo_head;
    assign bus.word_valid   = !fifo_empty;
    assign bus.fifo_level   = fifo_level;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_code     = cmd_code_q;
    assign bus.drop_count   = drop_q;
    assign bus.resync_count = resync_q;

endmodule

// File: tb/tb_uart_evt2_framer.sv
// Directed bench for uart_evt2_framer with CLKS_PER_BIT=4 (gap 80, timeout 160 cycles).
module tb_uart_evt2_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_evt2_framer_if #(.FIFO_DEPTH(4)) bus ();

    uart_evt2_framer #(
        .CLKS_PER_BIT  (4),
        .CMD_GAP_BYTES (2),
        .TIMEOUT_BYTES (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic drain4(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] e [4];
        e[0] = w0; e[1] = w1; e[2] = w2; e[3] = w3;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), bus.word_out, e[i]);
            tick();
        end
        bus.word_ready = 1'b0;
        check_eq({tag, "_empty"}, {31'd0, bus.word_valid}, 32'd0);
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.word_ready = 1'b0;
        idle(3);

        // Reset values
        check_eq("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
        check_eq("rst_word_out", bus.word_out, 32'd0);
        check_eq("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_eq("rst_cmd_code", {30'd0, bus.cmd_code}, 32'd0);
        check_eq("rst_level", {29'd0, bus.fifo_level}, 32'd0);
        check_eq("rst_drop", {24'd0, bus.drop_count}, 32'd0);
        check_eq("rst_resync", {24'd0, bus.resync_count}, 32'd0);
        rst = 1'b0;

        // Echo command right after reset
        send_byte(8'hFF);
        check_eq("echo_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("echo_code", {30'd0, bus.cmd_code}, 32'd0);
        check_eq("echo_no_word", {31'd0, bus.word_valid}, 32'd0);
        tick();
        check_eq("echo_pulse_end", {31'd0, bus.cmd_valid}, 32'd0);

        // Word assembly with 40-cycle byte spacing
        send_byte(8'h40); idle(39);
        send_byte(8'h12); idle(39);
        send_byte(8'h34); idle(39);
        send_byte(8'h56);
        check_eq("asm_valid", {31'd0, bus.word_valid}, 32'd1);
        check_eq("asm_word", bus.word_out, 32'h40123456);
        check_eq("asm_level", {29'd0, bus.fifo_level}, 32'd1);
        idle(39);
        send_byte(8'hFF);
        check_eq("asm_ctl_as_data", {31'd0, bus.cmd_valid}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check_eq("asm_level2", {29'd0, bus.fifo_level}, 32'd2);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        check_eq("asm_second_word", bus.word_out, 32'hFF010203);
        check_eq("asm_level_pop", {29'd0, bus.fifo_level}, 32'd1);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        check_eq("asm_drained", {31'd0, bus.word_valid}, 32'd0);

        // Timeout resync with a command byte after the gap
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(199);
        send_byte(8'hFE);
        check_eq("to_resync", {24'd0, bus.resync_count}, 32'd1);
        check_eq("to_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("to_cmd_code", {30'd0, bus.cmd_code}, 32'd1);
        check_eq("to_no_word", {31'd0, bus.word_valid}, 32'd0);
        tick();
        check_eq("to_pulse_end", {31'd0, bus.cmd_valid}, 32'd0);

        // Overflow: five words into a four-entry FIFO
        send_word(32'h01020304);
        send_word(32'h11121314);
        send_word(32'h21222324);
        send_word(32'h31323334);
        check_eq("ovf_level_full", {29'd0, bus.fifo_level}, 32'd4);
        check_eq("ovf_drop0", {24'd0, bus.drop_count}, 32'd0);
        send_word(32'h51525354);
        check_eq("ovf_level", {29'd0, bus.fifo_level}, 32'd4);
        check_eq("ovf_drop1", {24'd0, bus.drop_count}, 32'd1);
        check_eq("ovf_head", bus.word_out, 32'h01020304);
        drain4("ovf_drain", 32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334);

        // Full FIFO with a pop in the cycle the last byte arrives
        send_word(32'h61626364);
        send_word(32'h65666768);
        send_word(32'h696A6B6C);
        send_word(32'h6D6E6F70);
        send_byte(8'h7A);
        send_byte(8'h7B);
        send_byte(8'h7C);
        bus.word_ready = 1'b1;
        send_byte(8'h7D);
        bus.word_ready = 1'b0;
        check_eq("fpp_level", {29'd0, bus.fifo_level}, 32'd4);
        check_eq("fpp_drop", {24'd0, bus.drop_count}, 32'd1);
        drain4("fpp_drain", 32'h65666768, 32'h696A6B6C, 32'h6D6E6F70, 32'h7A7B7C7D);

        // Command gap boundary: idle 80 qualifies, idle 79 does not
        idle(80);
        send_byte(8'hFD);
        check_eq("gap80_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("gap80_cmd_code", {30'd0, bus.cmd_code}, 32'd2);
        idle(79);
        send_byte(8'hFC);
        check_eq("gap79_no_cmd", {31'd0, bus.cmd_valid}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check_eq("gap79_level", {29'd0, bus.fifo_level}, 32'd1);
        check_eq("gap79_word", bus.word_out, 32'hFC010203);

        // Reset mid-frame discards the partial word and FIFO contents
        send_byte(8'h99);
        send_byte(8'h88);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_level", {29'd0, bus.fifo_level}, 32'd0);
        check_eq("mrst_valid", {31'd0, bus.word_valid}, 32'd0);
        check_eq("mrst_word", bus.word_out, 32'd0);
        check_eq("mrst_drop", {24'd0, bus.drop_count}, 32'd0);
        send_word(32'h11223344);
        check_eq("mrst_new_word", bus.word_out, 32'h11223344);
        check_eq("mrst_new_level", {29'd0, bus.fifo_level}, 32'd1);
        check_eq("mrst_resync", {24'd0, bus.resync_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
